// File: rtl/nibble_deframer_pkg.sv
// Shared types and constants for the nibble deframer.
// Imported by the deframer top and its byte buffer.
package nibble_deframer_pkg;

  typedef enum logic [1:0] {
    HUNT,
    NIB_HI,
    NIB_LO
  } state_t;

  localparam logic [3:0] SYNC_PAT_DEF = 4'b1011;
  localparam int FIFO_DEPTH = 2;
  localparam int ENTRY_W = 9;

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry byte+last buffer feeding the byte-level logic.
// A pop frees a slot for a push on the same edge.
module byte_fifo2
  import nibble_deframer_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/nibble_deframer.sv
// Hunts a sync nibble in the shift-register window, then packs
// the following bits into bytes of a fixed-length frame.
module nibble_deframer
  import nibble_deframer_pkg::*;
#(
  parameter logic [3:0] SYNC_PAT    = SYNC_PAT_DEF,
  parameter int         FRAME_BYTES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       win_valid,
  input  logic [3:0] win,
  output logic [7:0] byte_data,
  output logic       byte_last,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       locked,
  output logic       overflow,
  input  logic       clr_overflow
);

  state_t     state;
  logic [1:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [3:0] hi;
  logic       nib_done;
  logic       is_last;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;

  assign nib_done = win_valid && (bit_cnt == 2'd3);
  assign is_last  = (byte_cnt == 8'(FRAME_BYTES - 1));
  assign push     = (state == NIB_LO) && nib_done;
  assign byte_valid = !empty;
  assign pop      = byte_valid && byte_ready;
  // dropped bytes still count toward the frame length
  assign drop     = push && full && !pop;

  byte_fifo2 u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({is_last, hi, win}),
    .pop   (pop),
    .rdata ({byte_last, byte_data}),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= HUNT;
      bit_cnt  <= 2'd0;
      byte_cnt <= 8'd0;
      hi       <= 4'd0;
      locked   <= 1'b0;
    end else if (win_valid) begin
      unique case (state)
        HUNT: begin
          if (win == SYNC_PAT) begin
            bit_cnt  <= 2'd0;
            byte_cnt <= 8'd0;
            state    <= NIB_HI;
            locked   <= 1'b1;
          end
        end
        NIB_HI: begin
          bit_cnt <= bit_cnt + 2'd1;
          if (nib_done) begin
            hi      <= win;
            bit_cnt <= 2'd0;
            state   <= NIB_LO;
          end
        end
        NIB_LO: begin
          bit_cnt <= bit_cnt + 2'd1;
          if (nib_done) begin
            bit_cnt <= 2'd0;
            if (is_last) begin
              state  <= HUNT;
              locked <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              state    <= NIB_HI;
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_nibble_deframer.sv
// Bench for nibble_deframer: frame table plus overflow,
// full-with-pop and mid-frame reset sequences.
module tb_nibble_deframer;

  localparam int FB = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       win_valid = 1'b0;
  logic [3:0] win = 4'd0;
  logic       byte_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_valid;
  logic       locked;
  logic       overflow;

  always #5 clk = ~clk;

  nibble_deframer #(
    .SYNC_PAT    (4'b1011),
    .FRAME_BYTES (FB)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .win_valid    (win_valid),
    .win          (win),
    .byte_data    (byte_data),
    .byte_last    (byte_last),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .locked       (locked),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         gap;
    int         lat;
  } vec_t;

  vec_t       tv [4];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         sync_cyc = 0;
  int         valid_cyc = -1;
  bit         armed = 1'b0;
  bit         gap_mode = 1'b0;
  logic       prev_valid = 1'b0;
  logic [3:0] sr = 4'd0;
  logic [8:0] expq [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn && byte_valid && byte_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_byte: got %0h want none",
                 {byte_last, byte_data});
      end else begin
        chk("byte", 32'({byte_last, byte_data}),
            32'(expq.pop_front()));
      end
    end
    if (armed && byte_valid && !prev_valid) begin
      valid_cyc = cyc;
      armed = 1'b0;
    end
    prev_valid = byte_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    sr = {sr[2:0], b};
    win = sr;
    win_valid = 1'b1;
    tick();
    if (gap_mode) begin
      win_valid = 1'b0;
      tick();
    end
    win_valid = 1'b0;
  endtask

  task automatic send_sync();
    logic [7:0] p;
    p = 8'b0000_1011;
    for (int i = 7; i >= 1; i--) shift_bit(p[i]);
    valid_cyc = -1;
    armed = 1'b1;
    shift_bit(p[0]);
    sync_cyc = gap_mode ? cyc - 1 : cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic lst,
                           input bit keep, input bit pop_last);
    if (keep) expq.push_back({lst, b});
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && pop_last) byte_ready = 1'b1;
      shift_bit(b[i]);
      if (i == 0 && pop_last) byte_ready = 1'b0;
    end
  endtask

  task automatic drain();
    byte_ready = 1'b1;
    for (int i = 0; i < 20 && (expq.size() != 0 || byte_valid); i++)
      tick();
    chk("drain_q", 32'(expq.size()), 32'd0);
    chk("drain_valid", 32'(byte_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] part;
    tv[0] = '{8'hA5, 8'h3C, 1'b0, 8};
    tv[1] = '{8'hA5, 8'h3C, 1'b1, 16};
    tv[2] = '{8'hBB, 8'h0B, 1'b0, 8};
    tv[3] = '{8'hC3, 8'hF0, 1'b0, 8};

    tick();
    tick();
    chk("rst_data", 32'(byte_data), 32'd0);
    chk("rst_last", 32'(byte_last), 32'd0);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rstn = 1'b1;
    tick();

    byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gap_mode = tv[i].gap;
      send_sync();
      chk("lock_rise", 32'(locked), 32'd1);
      send_byte(tv[i].b0, 1'b0, 1'b1, 1'b0);
      send_byte(tv[i].b1, 1'b1, 1'b1, 1'b0);
      chk("lock_fall", 32'(locked), 32'd0);
      drain();
      chk("latency", 32'(valid_cyc - sync_cyc), 32'(tv[i].lat));
    end
    gap_mode = 1'b0;

    // backpressure: second frame is dropped while clear is held
    byte_ready = 1'b0;
    send_sync();
    send_byte(8'h11, 1'b0, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1, 1'b0);
    chk("ovf_clean", 32'(overflow), 32'd0);
    send_sync();
    clr_overflow = 1'b1;
    send_byte(8'h33, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0, 1'b0);
    clr_overflow = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_head", 32'({byte_last, byte_data}), 32'h011);
    chk("ovf_valid", 32'(byte_valid), 32'd1);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // full buffer with a pop on each completing edge
    byte_ready = 1'b0;
    send_sync();
    send_byte(8'h11, 1'b0, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1, 1'b0);
    send_sync();
    send_byte(8'h33, 1'b0, 1'b1, 1'b1);
    send_byte(8'h44, 1'b1, 1'b1, 1'b1);
    chk("fwp_ovf", 32'(overflow), 32'd0);
    chk("fwp_head", 32'({byte_last, byte_data}), 32'h033);
    drain();

    // reset in the middle of the low nibble
    byte_ready = 1'b0;
    send_sync();
    send_byte(8'h5A, 1'b0, 1'b0, 1'b0);
    part = 8'h3C;
    for (int i = 7; i >= 2; i--) shift_bit(part[i]);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_valid", 32'(byte_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_data", 32'(byte_data), 32'd0);
    chk("mid_rst_last", 32'(byte_last), 32'd0);
    chk("mid_rst_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    byte_ready = 1'b1;
    send_sync();
    send_byte(8'h96, 1'b0, 1'b1, 1'b0);
    send_byte(8'h69, 1'b1, 1'b1, 1'b0);
    chk("post_rst_unlock", 32'(locked), 32'd0);
    drain();
    chk("post_rst_lat", 32'(valid_cyc - sync_cyc), 32'd8);

    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_deframer.md
# nibble_deframer

Downstream consumer of the 4-bit serial-in shift register. It watches the register's parallel window, hunts for a 4-bit sync pattern, then slices the following bit stream into nibbles. It packs nibble pairs into bytes and delivers a fixed-length frame through a 2-entry valid/ready buffer to the byte-level logic.

## Interface
- SYNC_PAT, 4'b1011, sync pattern that must appear in the window to start a frame
- FRAME_BYTES, 4, bytes per frame after sync; legal range 1..255
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- win_valid  in  1  a new bit was shifted into the window at the last edge; tie high when the register shifts every cycle
- win  in  4  shift-register window; win[0] is the newest bit
- byte_data  out  8  head-of-buffer byte; first nibble received is [7:4]
- byte_last  out  1  head byte is the final byte of its frame
- byte_valid  out  1  buffer not empty
- byte_ready  in  1  consumer accepts the head byte when byte_valid && byte_ready
- locked  out  1  high in any state other than HUNT
- overflow  out  1  sticky; set when a completed byte is dropped
- clr_overflow  in  1  synchronous clear of overflow

## Operation
- Gating: all state advances only on cycles with win_valid=1, except the buffer pop and clr_overflow.
- State machine, 3 states:
  - HUNT: if win_valid && win==SYNC_PAT, clear bit_cnt and byte_cnt, then go to NIB_HI. Otherwise stay.
  - NIB_HI: bit_cnt increments on win_valid. When win_valid && bit_cnt==3, latch hi=win, clear bit_cnt, go to NIB_LO.
  - NIB_LO: same 4-bit count. On the 4th bit, form {hi,win} and push it with last=(byte_cnt==FRAME_BYTES-1).
    - If last: go to HUNT.
    - Otherwise: byte_cnt++, go to NIB_HI.
- Sync matches are ignored while locked; there is no re-sync mid-frame.
- Frames may be back-to-back. The bits after a frame's last byte are hunted immediately, and a sync can complete 4 window bits later.
- Buffer: 2-entry FIFO, 9 bits wide (byte + last).
  - A pop occurs when byte_valid && byte_ready.
  - A push while full with a pop in the same cycle is accepted (pop first).
  - A push while full without a pop drops the byte and sets overflow. The frame continues, and byte_cnt still advances.
- overflow: if set and clear occur in the same cycle, set wins.
- Widths: bit_cnt 2 bits, byte_cnt 8 bits, no wrap possible within the legal FRAME_BYTES range.

## Timing
- Reset values: byte_data=0, byte_last=0, byte_valid=0, locked=0, overflow=0. FSM returns to HUNT, counters clear, FIFO empties.
- Reset mid-frame: the partial byte is discarded and the buffered bytes are lost.
- locked rises the cycle after the sync edge and falls the cycle after the last-byte push.
- A byte pushed at edge N is visible on byte_data/byte_valid after edge N when the buffer was empty. Latency is one cycle from the capturing edge.
- Byte period with win_valid always high: 8 cycles per byte. Sync to first byte_valid: 8 cycles.
- byte_valid, byte_data and byte_last are stable while byte_valid && !byte_ready.
- Outputs are registered, with no combinational path from byte_ready to byte_valid.

## Structure
- Package nibble_deframer_pkg holds:
  - state enum {HUNT, NIB_HI, NIB_LO}
  - default SYNC_PAT
  - FIFO_DEPTH=2
  - the byte+last entry width (9)
- One sub-module, byte_fifo2: 2-entry synchronous FIFO with push/pop/full/empty, pop-before-push when full, async active-low reset.

## Test plan
- Basic frame, FRAME_BYTES=2, win_valid=1:
  - Stimulus: shift bits 1,0,1,1, then 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0.
  - Response: bytes 0xA5 (last=0) and 0x3C (last=1). First byte_valid 8 cycles after sync. locked drops after 0x3C.
- Backpressure/overflow:
  - Stimulus: byte_ready=0 for a 4-byte frame 0x11,0x22,0x33,0x44.
  - Response: buffer holds 0x11,0x22. overflow=1. Releasing byte_ready yields exactly 0x11 then 0x22.
  - Then pulse clr_overflow: overflow=0.
- Full-with-pop:
  - Stimulus: buffer full, byte_ready=1 on the same cycle a byte completes.
  - Response: no overflow, byte order preserved.
- win_valid gaps:
  - Stimulus: the basic frame with win_valid toggling 1,0,1,0.
  - Response: identical bytes 0xA5/0x3C at half rate.
- In-frame sync pattern and reset:
  - Stimulus: a payload containing 1011 is ignored (byte 0xBB delivered).
  - Stimulus: assert rstn=0 mid-NIB_LO.
  - Response: all outputs 0, HUNT. The next sync yields a clean frame.
